// File: rtl/des_subkey_sched.sv
// des_subkey_sched: sequential DES key schedule.
// Takes one 64-bit key and streams the sixteen 48-bit round subkeys, one per
// valid/ready handshake. Encrypt mode walks K1..K16 with left rotations;
// decrypt mode walks K16..K1 with right rotations so the round datapath is
// shared. C and D are the only schedule state. PC2 is plain wiring from
// {C,D} to the subkey port.
// Build option: define DES_KEY_PARITY_CHECK_EN to add the odd-parity key
// byte checker on parity_err (tied low otherwise; ports identical).
`timescale 1ns/1ps
module des_subkey_sched #(
    parameter int NROUNDS = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] key_in,
    input  logic        decrypt,
    input  logic        key_valid,
    output logic        key_ready,
    output logic [47:0] subkey_out,
    output logic [3:0]  subkey_idx,
    output logic        subkey_valid,
    input  logic        subkey_ready,
    output logic        done,
    output logic        parity_err
);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    localparam logic [3:0] LAST_CNT = 4'(NROUNDS - 1);

    // Permuted choice 1. DES bit n sits at k[64-n]; the eight parity bits
    // (k[56], k[48], ..., k[0]) are dropped. Result is {C, D}, C bit 1 = [55].
    function automatic logic [55:0] pc1(input logic [63:0] k);
        return {k[7],  k[15], k[23], k[31], k[39], k[47], k[55],
                k[63], k[6],  k[14], k[22], k[30], k[38], k[46],
                k[54], k[62], k[5],  k[13], k[21], k[29], k[37],
                k[45], k[53], k[61], k[4],  k[12], k[20], k[28],
                k[1],  k[9],  k[17], k[25], k[33], k[41], k[49],
                k[57], k[2],  k[10], k[18], k[26], k[34], k[42],
                k[50], k[58], k[3],  k[11], k[19], k[27], k[35],
                k[43], k[51], k[59], k[36], k[44], k[52], k[60]};
    endfunction

    // Left rotation of a 28-bit half by one or two places.
    function automatic logic [27:0] rol28(input logic [27:0] x, input logic [1:0] amt);
        logic [27:0] r;
        case (amt)
            2'd2:    r = {x[25:0], x[27:26]};
            default: r = {x[26:0], x[27]};
        endcase
        return r;
    endfunction

    // Right rotation of a 28-bit half by one or two places.
    function automatic logic [27:0] ror28(input logic [27:0] x, input logic [1:0] amt);
        logic [27:0] r;
        case (amt)
            2'd2:    r = {x[1:0], x[27:2]};
            default: r = {x[0], x[27:1]};
        endcase
        return r;
    endfunction

    // Rotation count for DES round 1..16: single shift on rounds 1, 2, 9, 16.
    function automatic logic [1:0] shift_amt(input logic [4:0] round);
        logic [1:0] a;
        case (round)
            5'd1, 5'd2, 5'd9, 5'd16: a = 2'd1;
            default:                 a = 2'd2;
        endcase
        return a;
    endfunction

`ifdef DES_KEY_PARITY_CHECK_EN
    // High when any key byte has even parity (DES keys use odd parity).
    function automatic logic key_parity_bad(input logic [63:0] k);
        return (~^k[63:56]) | (~^k[55:48]) | (~^k[47:40]) | (~^k[39:32]) |
               (~^k[31:24]) | (~^k[23:16]) | (~^k[15:8])  | (~^k[7:0]);
    endfunction
`endif

    state_t      state_r, state_nxt_s;
    logic [27:0] c_r, c_nxt_s;
    logic [27:0] d_r, d_nxt_s;
    logic [3:0]  cnt_r, cnt_nxt_s;
    logic        mode_r, mode_nxt_s;
    logic [3:0]  idx_r, idx_nxt_s;
    logic        key_ready_r, key_ready_nxt_s;
    logic        valid_r, valid_nxt_s;
    logic        done_r, done_nxt_s;

    logic [55:0] pc1_s;
    logic [27:0] pc1_c_s;
    logic [27:0] pc1_d_s;
    logic [3:0]  cnt_inc_s;
    logic [1:0]  enc_amt_s;
    logic [1:0]  dec_amt_s;
    logic        key_accept_s;
    logic        step_accept_s;
    logic [55:0] cd_s;

    assign pc1_s   = pc1(key_in);
    assign pc1_c_s = pc1_s[55:28];
    assign pc1_d_s = pc1_s[27:0];

    assign cnt_inc_s = cnt_r + 4'd1;
    // Encrypt step after subkey cnt moves to round cnt+2; decrypt step after
    // subkey (16-cnt) undoes that round's rotation.
    assign enc_amt_s = shift_amt({1'b0, cnt_r} + 5'd2);
    assign dec_amt_s = shift_amt(5'd16 - {1'b0, cnt_r});

    assign key_accept_s  = (state_r == IDLE) & key_valid & key_ready_r;
    assign step_accept_s = valid_r & subkey_ready;

    // State register for the schedule controller
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state and next-output decode for the two-state schedule controller
    always_comb begin
        state_nxt_s     = state_r;
        c_nxt_s         = c_r;
        d_nxt_s         = d_r;
        cnt_nxt_s       = cnt_r;
        mode_nxt_s      = mode_r;
        idx_nxt_s       = idx_r;
        key_ready_nxt_s = key_ready_r;
        valid_nxt_s     = valid_r;
        done_nxt_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (key_accept_s) begin
                    state_nxt_s = ACTIVE;
                    if (decrypt) begin
                        // Total rotation is 28, so C16/D16 equal PC1 output.
                        c_nxt_s = pc1_c_s;
                        d_nxt_s = pc1_d_s;
                    end else begin
                        c_nxt_s = rol28(pc1_c_s, 2'd1);
                        d_nxt_s = rol28(pc1_d_s, 2'd1);
                    end
                    cnt_nxt_s       = 4'd0;
                    mode_nxt_s      = decrypt;
                    idx_nxt_s       = decrypt ? LAST_CNT : 4'd0;
                    key_ready_nxt_s = 1'b0;
                    valid_nxt_s     = 1'b1;
                end else begin
                    key_ready_nxt_s = 1'b1;
                    valid_nxt_s     = 1'b0;
                end
            end
            ACTIVE: begin
                key_ready_nxt_s = 1'b0;
                valid_nxt_s     = 1'b1;
                if (step_accept_s) begin
                    if (cnt_r == LAST_CNT) begin
                        state_nxt_s     = IDLE;
                        cnt_nxt_s       = 4'd0;
                        key_ready_nxt_s = 1'b1;
                        valid_nxt_s     = 1'b0;
                        done_nxt_s      = 1'b1;
                    end else begin
                        cnt_nxt_s = cnt_inc_s;
                        if (mode_r) begin
                            c_nxt_s   = ror28(c_r, dec_amt_s);
                            d_nxt_s   = ror28(d_r, dec_amt_s);
                            idx_nxt_s = LAST_CNT - cnt_inc_s;
                        end else begin
                            c_nxt_s   = rol28(c_r, enc_amt_s);
                            d_nxt_s   = rol28(d_r, enc_amt_s);
                            idx_nxt_s = cnt_inc_s;
                        end
                    end
                end else begin
                    // Backpressure: everything holds.
                    cnt_nxt_s = cnt_r;
                end
            end
            default: begin
                state_nxt_s     = IDLE;
                key_ready_nxt_s = 1'b0;
                valid_nxt_s     = 1'b0;
            end
        endcase
    end

    // Schedule datapath and registered handshake outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            c_r         <= 28'd0;
            d_r         <= 28'd0;
            cnt_r       <= 4'd0;
            mode_r      <= 1'b0;
            idx_r       <= 4'd0;
            key_ready_r <= 1'b0;
            valid_r     <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            c_r         <= c_nxt_s;
            d_r         <= d_nxt_s;
            cnt_r       <= cnt_nxt_s;
            mode_r      <= mode_nxt_s;
            idx_r       <= idx_nxt_s;
            key_ready_r <= key_ready_nxt_s;
            valid_r     <= valid_nxt_s;
            done_r      <= done_nxt_s;
        end
    end

    // Permuted choice 2: direct wiring from the C/D registers.
    assign cd_s = {c_r, d_r};
    assign subkey_out = {cd_s[42], cd_s[39], cd_s[45], cd_s[32], cd_s[55], cd_s[51],
                         cd_s[53], cd_s[28], cd_s[41], cd_s[50], cd_s[35], cd_s[46],
                         cd_s[33], cd_s[37], cd_s[44], cd_s[52], cd_s[30], cd_s[48],
                         cd_s[40], cd_s[49], cd_s[29], cd_s[36], cd_s[43], cd_s[54],
                         cd_s[15], cd_s[4],  cd_s[25], cd_s[19], cd_s[9],  cd_s[1],
                         cd_s[26], cd_s[16], cd_s[5],  cd_s[11], cd_s[23], cd_s[8],
                         cd_s[12], cd_s[7],  cd_s[17], cd_s[0],  cd_s[22], cd_s[3],
                         cd_s[10], cd_s[14], cd_s[6],  cd_s[20], cd_s[27], cd_s[24]};

    assign key_ready    = key_ready_r;
    assign subkey_idx   = idx_r;
    assign subkey_valid = valid_r;
    assign done         = done_r;

`ifdef DES_KEY_PARITY_CHECK_EN
    logic parity_err_r;

    // Flag an even-parity key byte during the first cycle of its schedule
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            parity_err_r <= 1'b0;
        end else begin
            parity_err_r <= key_accept_s ? key_parity_bad(key_in) : 1'b0;
        end
    end

    assign parity_err = parity_err_r;
`else
    // The parity bits only feed the optional checker.
    logic unused_parity_s;
    assign unused_parity_s = ^{key_in[56], key_in[48], key_in[40], key_in[32],
                               key_in[24], key_in[16], key_in[8],  key_in[0]};
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_des_subkey_sched.sv
// Scoreboard bench for des_subkey_sched: accepted keys push their expected
// subkey stream (from a table-driven reference schedule) into a queue; a
// negedge monitor pops and compares on every subkey handshake.
`timescale 1ns/1ps
module tb_des_subkey_sched;

    logic        clk;
    logic        reset;
    logic [63:0] key_in;
    logic        decrypt;
    logic        key_valid;
    logic        key_ready;
    logic [47:0] subkey_out;
    logic [3:0]  subkey_idx;
    logic        subkey_valid;
    logic        subkey_ready;
    logic        done;
    logic        parity_err;

    des_subkey_sched #(.NROUNDS(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .key_in       (key_in),
        .decrypt      (decrypt),
        .key_valid    (key_valid),
        .key_ready    (key_ready),
        .subkey_out   (subkey_out),
        .subkey_idx   (subkey_idx),
        .subkey_valid (subkey_valid),
        .subkey_ready (subkey_ready),
        .done         (done),
        .parity_err   (parity_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [63:0] KAT_KEY  = 64'h133457799BBCDFF1;
    localparam logic [63:0] BAD_KEY  = 64'h133457799BBCDFF0;
    localparam logic [63:0] KEY2     = 64'h0E329232EA6D0D73;
    localparam logic [47:0] KAT_K1   = 48'h1B02EFFC7072;
    localparam logic [47:0] KAT_K2   = 48'h79AED9DBC9E5;
    localparam logic [47:0] KAT_K16  = 48'hCB3D8B0E17F5;

    localparam int PC1_T [56] = '{57, 49, 41, 33, 25, 17, 9,  1,  58, 50, 42, 34, 26, 18,
                                  10, 2,  59, 51, 43, 35, 27, 19, 11, 3,  60, 52, 44, 36,
                                  63, 55, 47, 39, 31, 23, 15, 7,  62, 54, 46, 38, 30, 22,
                                  14, 6,  61, 53, 45, 37, 29, 21, 13, 5,  28, 20, 12, 4};
    localparam int PC2_T [48] = '{14, 17, 11, 24, 1,  5,  3,  28, 15, 6,  21, 10,
                                  23, 19, 12, 4,  26, 8,  16, 7,  27, 20, 13, 2,
                                  41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
                                  44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
    localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    typedef struct packed {
        logic [47:0] sk;
        logic [3:0]  idx;
        logic        last;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    int          n_checks = 0;
    int          n_pass   = 0;
    int          n_done   = 0;
    int          exp_runs = 0;
    logic        exp_done = 1'b0;
    logic        par_exp  = 1'b0;
    logic        hold_v   = 1'b0;
    logic [47:0] hold_key;
    logic [3:0]  hold_idx;
    logic        rnd_ready = 1'b0;

    // Reference: subkey for DES round 1..16 = PC2 of PC1(key) with both
    // halves rotated left by the cumulative shift count up to that round.
    function automatic logic [47:0] model_subkey(input logic [63:0] key, input int round);
        logic [1:64] kb;
        logic [1:56] cd;
        logic [1:56] rcd;
        logic [1:48] sk;
        int          sh;
        kb = key;
        for (int i = 0; i < 56; i++) cd[i + 1] = kb[PC1_T[i]];
        sh = 0;
        for (int r = 0; r < round; r++) sh += SHIFTS[r];
        for (int i = 0; i < 28; i++) begin
            rcd[i + 1]  = cd[((i + sh) % 28) + 1];
            rcd[i + 29] = cd[((i + sh) % 28) + 29];
        end
        for (int j = 0; j < 48; j++) sk[j + 1] = rcd[PC2_T[j]];
        return sk;
    endfunction

    function automatic logic model_parity_bad(input logic [63:0] key);
        logic bad;
        bad = 1'b0;
        for (int b = 0; b < 8; b++) begin
            if (($countones(key >> (8 * b)) - $countones(key >> (8 * b + 8))) % 2 == 0) bad = 1'b1;
        end
        return bad;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Present a key until accepted; on acceptance push its expected stream.
    task automatic send_key(input logic [63:0] k, input logic dec, output int lat);
        exp_t e;
        bit   ok;
        ok  = 1'b0;
        lat = 0;
        key_in    = k;
        decrypt   = dec;
        key_valid = 1'b1;
        for (int n = 0; n < 100 && !ok; n++) begin
            if (key_ready) ok = 1'b1;
            else lat++;
            @(posedge clk); #1;
        end
        key_valid = 1'b0;
        key_in    = {$urandom, $urandom};
        if (!ok) begin
            check("key_accept_timeout", 64'd0, 64'd1);
            lat = -1;
        end else begin
            for (int i = 0; i < 16; i++) begin
                e.idx  = dec ? 4'(15 - i) : 4'(i);
                e.sk   = model_subkey(k, dec ? (16 - i) : (i + 1));
                e.last = (i == 15);
                sb_q.push_back(e);
            end
`ifdef DES_KEY_PARITY_CHECK_EN
            par_exp = model_parity_bad(k);
`else
            par_exp = 1'b0;
`endif
        end
    endtask

    // Wait (bounded) for done; optionally spray ignored keys meanwhile.
    task automatic wait_done(input bit noise);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 400 && !seen; n++) begin
            if (done) begin
                seen = 1'b1;
            end else begin
                if (noise) begin
                    key_valid = 1'($urandom_range(0, 1));
                    key_in    = {$urandom, $urandom};
                    decrypt   = 1'($urandom_range(0, 1));
                end
                @(posedge clk); #1;
            end
        end
        key_valid = 1'b0;
        check("done_seen", 64'(seen), 64'd1);
    endtask

    // Consumer ready: constant 1 or ~50% random
    initial begin
        subkey_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            subkey_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: scoreboard pops, hold stability, done and parity pulses
    always @(negedge clk) begin
        if (!reset) begin
            sb_q.delete();
            exp_done = 1'b0;
            hold_v   = 1'b0;
            par_exp  = 1'b0;
            check("rst_valid", 64'(subkey_valid), 64'd0);
            check("rst_key_ready", 64'(key_ready), 64'd0);
            check("rst_done", 64'(done), 64'd0);
        end else begin
            check("done_pulse", 64'(done), 64'(exp_done));
            if (done) n_done++;
            exp_done = 1'b0;
            check("parity_err", 64'(parity_err), 64'(par_exp));
            par_exp = 1'b0;
            if (hold_v) begin
                check("hold_valid", 64'(subkey_valid), 64'd1);
                check("hold_subkey", 64'(subkey_out), 64'(hold_key));
                check("hold_idx", 64'(subkey_idx), 64'(hold_idx));
            end
            if (subkey_valid) begin
                check("key_ready_active", 64'(key_ready), 64'd0);
                if (subkey_ready) begin
                    hold_v = 1'b0;
                    if (sb_q.size() == 0) begin
                        check("sb_unexpected_subkey", 64'(subkey_out), 64'd0);
                    end else begin
                        mon_e = sb_q.pop_front();
                        check("subkey", 64'(subkey_out), 64'(mon_e.sk));
                        check("subkey_idx", 64'(subkey_idx), 64'(mon_e.idx));
                        if (mon_e.last) exp_done = 1'b1;
                    end
                end else begin
                    hold_v   = 1'b1;
                    hold_key = subkey_out;
                    hold_idx = subkey_idx;
                end
            end else begin
                hold_v = 1'b0;
            end
        end
    end

    initial begin
        int  lat;
        bit  found;
        reset     = 1'b1;
        key_in    = 64'd0;
        decrypt   = 1'b0;
        key_valid = 1'b0;
        #2 reset  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_subkey", 64'(subkey_out), 64'd0);
        check("reset_idx", 64'(subkey_idx), 64'd0);
        check("reset_parity", 64'(parity_err), 64'd0);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("ready_after_reset", 64'(key_ready), 64'd1);

        // Known-answer encrypt run
        send_key(KAT_KEY, 1'b0, lat);
        check("kat_k1", 64'(subkey_out), 64'(KAT_K1));
        check("kat_k1_idx", 64'(subkey_idx), 64'd0);
        @(posedge clk); #1;
        check("kat_k2", 64'(subkey_out), 64'(KAT_K2));
        check("kat_k2_idx", 64'(subkey_idx), 64'd1);
        repeat (14) @(posedge clk);
        #1;
        check("kat_k16", 64'(subkey_out), 64'(KAT_K16));
        check("kat_k16_idx", 64'(subkey_idx), 64'd15);
        wait_done(1'b0);
        exp_runs++;

        // Known-answer decrypt run
        send_key(KAT_KEY, 1'b1, lat);
        check("dec_first", 64'(subkey_out), 64'(KAT_K16));
        check("dec_first_idx", 64'(subkey_idx), 64'd15);
        repeat (15) @(posedge clk);
        #1;
        check("dec_last", 64'(subkey_out), 64'(KAT_K1));
        check("dec_last_idx", 64'(subkey_idx), 64'd0);
        wait_done(1'b0);
        exp_runs++;

        // Random backpressure with ignored key_valid pulses
        rnd_ready = 1'b1;
        send_key(KAT_KEY, 1'b0, lat);
        wait_done(1'b1);
        exp_runs++;
        rnd_ready = 1'b0;

        // Second key presented in the done cycle
        send_key(KEY2, 1'b0, lat);
        check("b2b_latency", 64'(lat), 64'd0);
        check("b2b_valid", 64'(subkey_valid), 64'd1);
        check("b2b_idx", 64'(subkey_idx), 64'd0);
        wait_done(1'b0);
        exp_runs++;

        // Reset at cnt = 7
        send_key(KAT_KEY, 1'b0, lat);
        found = 1'b0;
        for (int n = 0; n < 50 && !found; n++) begin
            if (subkey_valid && subkey_idx == 4'd7) found = 1'b1;
            else begin
                @(posedge clk); #1;
            end
        end
        check("reach_cnt7", 64'(found), 64'd1);
        reset = 1'b0;
        #1;
        check("midrst_valid", 64'(subkey_valid), 64'd0);
        check("midrst_key_ready", 64'(key_ready), 64'd0);
        check("midrst_subkey", 64'(subkey_out), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("midrst_ready_after", 64'(key_ready), 64'd1);
        send_key(KAT_KEY, 1'b0, lat);
        check("midrst_k1", 64'(subkey_out), 64'(KAT_K1));
        wait_done(1'b0);
        exp_runs++;

        // Key with a bad parity byte: schedule unaffected
        send_key(BAD_KEY, 1'b0, lat);
        check("badpar_k1", 64'(subkey_out), 64'(KAT_K1));
        wait_done(1'b0);
        exp_runs++;

        // Random keys, random direction, random backpressure
        rnd_ready = 1'b1;
        for (int r = 0; r < 4; r++) begin
            send_key({$urandom, $urandom}, 1'($urandom_range(0, 1)), lat);
            wait_done(1'b1);
            exp_runs++;
        end
        rnd_ready = 1'b0;

        repeat (4) @(posedge clk);
        #1;
        check("sb_drained", 64'(sb_q.size()), 64'd0);
        check("done_count", 64'(n_done), 64'(exp_runs));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/des_subkey_sched.md
Name: des_subkey_sched

Overview:
- Sequential DES key schedule. Accepts one 64-bit key and streams the sixteen 48-bit round subkeys to the round engine, one per handshake.
- Encrypt mode emits K1..K16 using left rotations.
- Decrypt mode emits K16..K1 using right rotations. This is the reverse-direction schedule, so the same f(R,K) and S-box datapath serves decryption.
- Sits between the key register interface and the per-round f(R,K) block.

Parameters:
- NROUNDS, 16, subkeys emitted per key. Fixed at 16 for DES; exposed only for bench shortening.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous active-low reset
- key_in  input  64  DES key; DES bit 1 = key_in[63]; parity bits ignored by the schedule
- decrypt  input  1  sampled with key_in; 0 = encrypt order, 1 = decrypt order
- key_valid  input  1  key_in/decrypt valid
- key_ready  output  1  block can accept a key
- subkey_out  output  48  current subkey; DES bit 1 = subkey_out[47]
- subkey_idx  output  4  round number of subkey_out, minus 1 (0..15)
- subkey_valid  output  1  subkey_out valid
- subkey_ready  input  1  consumer accepts subkey_out
- done  output  1  one-cycle pulse after the final subkey is accepted
- parity_err  output  1  see Optional Feature

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - state = IDLE; C, D, round counter, mode and all outputs = 0.
  - key_ready = 1 after reset release.
- Shift schedule S[1..16] = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
- Shift registers: C and D are 28-bit registers. PC1 loads them. PC2 is pure wiring from {C,D} to subkey_out, with no logic between registers and port.
- States: IDLE, ACTIVE.
- IDLE:
  - key_ready = 1, subkey_valid = 0.
  - Accept on key_valid & key_ready. At that edge:
    - {C,D} <= PC1(key_in).
    - Rotate left by 1 if decrypt = 0; no rotation if decrypt = 1.
    - mode <= decrypt; cnt <= 0; state -> ACTIVE.
- ACTIVE:
  - key_ready = 0, subkey_valid = 1.
  - subkey_idx = cnt in encrypt mode; 15 - cnt in decrypt mode.
  - Accept on subkey_valid & subkey_ready. At the accept edge with cnt < 15:
    - cnt++.
    - Encrypt: rotate C and D left by S[cnt+2].
    - Decrypt: rotate C and D right by S[16-cnt].
  - Accept edge with cnt = 15: state -> IDLE, done = 1 for exactly the next cycle.
- Latency:
  - First subkey is valid in the cycle after key acceptance.
  - One subkey per cycle under continuous subkey_ready, i.e. 16 cycles per key.
  - key_ready reasserts in the same cycle done pulses; a new key may be accepted then, with no dead cycle.
- Backpressure: with subkey_ready = 0, subkey_out, subkey_idx, subkey_valid, C, D and cnt hold indefinitely.
- key_valid while ACTIVE: ignored. key_ready = 0; the key is neither captured nor lost-flagged.
- Wrap-around: total rotation over 16 rounds = 28, so C and D return to PC1(key) after the final step. No extra reload is needed.
- Reset mid-operation: aborts immediately to IDLE. No done pulse; subkey_valid drops asynchronously.

Optional Feature:
- Macro: DES_KEY_PARITY_CHECK_EN.
- Defined:
  - On key acceptance, each of the 8 key bytes is checked for odd parity.
  - parity_err pulses high for one cycle (the first ACTIVE cycle) if any byte has even parity.
  - The key is still processed normally.
- Undefined: parity_err tied 0 and no checker logic is generated.
- Port list is identical in both builds.

Test Plan:
- Reset, then key 0x133457799BBCDFF1, decrypt = 0, subkey_ready = 1:
  - Cycle after accept: subkey_out = 0x1B02EFFC7072, idx 0.
  - Next cycle: 0x79AED9DBC9E5, idx 1.
  - 16th subkey: 0xCB3D8B0E17F5, idx 15.
  - done pulses once.
- Same key, decrypt = 1: first subkey 0xCB3D8B0E17F5 with idx 15; last subkey 0x1B02EFFC7072 with idx 0; sequence is exactly the reverse of the encrypt run.
- Encrypt run with subkey_ready toggled randomly (about 50%):
  - Identical 16-value sequence.
  - Outputs stable while ready = 0.
  - key_valid pulses during ACTIVE are ignored (key_ready = 0 throughout).
- Back-to-back: second key 0x0E329232EA6D0D73 presented in the done cycle → accepted with no idle cycle; its K1 follows immediately.
- reset asserted at cnt = 7 → subkey_valid = 0 and key_ready = 0 while reset is low; after release key_ready = 1, no done pulse; the next key runs correctly from K1.
- DES_KEY_PARITY_CHECK_EN defined:
  - Key 0x133457799BBCDFF1 (odd parity) → parity_err stays 0.
  - Key 0x133457799BBCDFF0 → one parity_err pulse and the subkeys are still correct.
  - Undefined build: parity_err is always 0.
